// File: rtl/reservation_station_pkg.sv
// Shared types and default sizing for the reservation station slice.
// Holds the OPENUM opcode encoding used on the issue and ALU dispatch buses.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE_DFLT   = 16;
  localparam int unsigned RS_IDX_W_DFLT  = 4;
  localparam int unsigned ROB_IDX_W_DFLT = 4;
  localparam int unsigned DATA_W_DFLT    = 32;
  localparam int unsigned ADDR_W_DFLT    = 32;
  localparam int unsigned OP_W_DFLT      = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Integer / branch opcodes handled by the ALU
  typedef enum logic [OP_W_DFLT-1:0] {
    OPENUM_NOP   = 6'd0,
    OPENUM_ADD   = 6'd1,
    OPENUM_SUB   = 6'd2,
    OPENUM_AND   = 6'd3,
    OPENUM_OR    = 6'd4,
    OPENUM_XOR   = 6'd5,
    OPENUM_SLL   = 6'd6,
    OPENUM_SRL   = 6'd7,
    OPENUM_SRA   = 6'd8,
    OPENUM_SLT   = 6'd9,
    OPENUM_SLTU  = 6'd10,
    OPENUM_ADDI  = 6'd11,
    OPENUM_ANDI  = 6'd12,
    OPENUM_ORI   = 6'd13,
    OPENUM_XORI  = 6'd14,
    OPENUM_SLLI  = 6'd15,
    OPENUM_SRLI  = 6'd16,
    OPENUM_SRAI  = 6'd17,
    OPENUM_SLTI  = 6'd18,
    OPENUM_SLTIU = 6'd19,
    OPENUM_BEQ   = 6'd20,
    OPENUM_BNE   = 6'd21,
    OPENUM_BLT   = 6'd22,
    OPENUM_BGE   = 6'd23,
    OPENUM_BLTU  = 6'd24,
    OPENUM_BGEU  = 6'd25,
    OPENUM_JAL   = 6'd26,
    OPENUM_JALR  = 6'd27,
    OPENUM_LUI   = 6'd28,
    OPENUM_AUIPC = 6'd29
  } openum_t;

endpackage

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest set bit.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int unsigned N     = RS_SIZE_DFLT,
  parameter int unsigned IDX_W = RS_IDX_W_DFLT
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan upward; the first hit locks in the result
  always_comb begin
    found = FALSE;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = TRUE;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for integer/branch ops: buffers issued ops, snoops the
// ALU and LSB CDB ports for pending operands and sends one ready op per cycle
// to the ALU. Optional macro RS_WAKEUP_DISPATCH_EN lets an entry whose last
// operand arrives on the CDB be selected in that same cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE   = RS_SIZE_DFLT,
  parameter int unsigned RS_IDX_W  = RS_IDX_W_DFLT,
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DFLT,
  parameter int unsigned DATA_W    = DATA_W_DFLT,
  parameter int unsigned ADDR_W    = ADDR_W_DFLT,
  parameter int unsigned OP_W      = OP_W_DFLT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,

  input  logic                 issue_valid,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic                 issue_rs1_pend,
  input  logic                 issue_rs2_pend,
  input  logic [ROB_IDX_W-1:0] issue_rs1_tag,
  input  logic [ROB_IDX_W-1:0] issue_rs2_tag,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  input  logic [ADDR_W-1:0]    issue_pc,
  input  logic [DATA_W-1:0]    issue_imm,
  output logic                 rs_full,

  input  logic                 alu_cdb_valid,
  input  logic [DATA_W-1:0]    alu_cdb_result,
  input  logic [ROB_IDX_W-1:0] alu_cdb_rob_index,
  input  logic                 lsb_cdb_valid,
  input  logic [DATA_W-1:0]    lsb_cdb_result,
  input  logic [ROB_IDX_W-1:0] lsb_cdb_rob_index,

  output logic                 rs_to_alu_ready,
  output logic [OP_W-1:0]      rs_to_alu_op,
  output logic [DATA_W-1:0]    rs_to_alu_rs1,
  output logic [DATA_W-1:0]    rs_to_alu_rs2,
  output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
  output logic [ADDR_W-1:0]    rs_to_alu_PC,
  output logic [DATA_W-1:0]    rs_to_alu_imm
);

  // Entry storage
  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   pendj;
  logic [RS_SIZE-1:0]   pendk;
  logic [OP_W-1:0]      op_q  [RS_SIZE];
  logic [DATA_W-1:0]    vj_q  [RS_SIZE];
  logic [DATA_W-1:0]    vk_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_q [RS_SIZE];
  logic [ADDR_W-1:0]    pc_q  [RS_SIZE];
  logic [DATA_W-1:0]    imm_q [RS_SIZE];

  // Wake-up / selection signals
  logic [RS_SIZE-1:0]   wake_j;
  logic [RS_SIZE-1:0]   wake_k;
  logic [DATA_W-1:0]    wake_vj [RS_SIZE];
  logic [DATA_W-1:0]    wake_vk [RS_SIZE];
  logic [RS_SIZE-1:0]   ready_vec;

  logic                 free_found;
  logic [RS_IDX_W-1:0]  free_idx;
  logic                 disp_found;
  logic [RS_IDX_W-1:0]  disp_idx;
  logic                 issue_fire;

  logic                 iss_pendj;
  logic                 iss_pendk;
  logic [DATA_W-1:0]    iss_vj;
  logic [DATA_W-1:0]    iss_vk;
  logic [DATA_W-1:0]    disp_vj;
  logic [DATA_W-1:0]    disp_vk;

  assign rs_full    = &busy;
  assign issue_fire = issue_valid & free_found & ~rs_full;

  // Per-entry CDB tag match and readiness
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      wake_j[i]  = busy[i] & pendj[i] &
                   ((alu_cdb_valid & (alu_cdb_rob_index == qj_q[i])) |
                    (lsb_cdb_valid & (lsb_cdb_rob_index == qj_q[i])));
      wake_k[i]  = busy[i] & pendk[i] &
                   ((alu_cdb_valid & (alu_cdb_rob_index == qk_q[i])) |
                    (lsb_cdb_valid & (lsb_cdb_rob_index == qk_q[i])));
      wake_vj[i] = (alu_cdb_valid && (alu_cdb_rob_index == qj_q[i])) ?
                   alu_cdb_result : lsb_cdb_result;
      wake_vk[i] = (alu_cdb_valid && (alu_cdb_rob_index == qk_q[i])) ?
                   alu_cdb_result : lsb_cdb_result;
`ifdef RS_WAKEUP_DISPATCH_EN
      ready_vec[i] = busy[i] & (~pendj[i] | wake_j[i]) & (~pendk[i] | wake_k[i]);
`else
      ready_vec[i] = busy[i] & ~pendj[i] & ~pendk[i];
`endif
    end
  end

  // Operand capture at issue, including a same-cycle CDB broadcast of the tag
  always_comb begin
    iss_pendj = issue_rs1_pend;
    iss_vj    = issue_rs1_val;
    if (issue_rs1_pend) begin
      if (alu_cdb_valid && (alu_cdb_rob_index == issue_rs1_tag)) begin
        iss_pendj = FALSE;
        iss_vj    = alu_cdb_result;
      end else if (lsb_cdb_valid && (lsb_cdb_rob_index == issue_rs1_tag)) begin
        iss_pendj = FALSE;
        iss_vj    = lsb_cdb_result;
      end
    end
    iss_pendk = issue_rs2_pend;
    iss_vk    = issue_rs2_val;
    if (issue_rs2_pend) begin
      if (alu_cdb_valid && (alu_cdb_rob_index == issue_rs2_tag)) begin
        iss_pendk = FALSE;
        iss_vk    = alu_cdb_result;
      end else if (lsb_cdb_valid && (lsb_cdb_rob_index == issue_rs2_tag)) begin
        iss_pendk = FALSE;
        iss_vk    = lsb_cdb_result;
      end
    end
  end

  // Operand values of the selected entry, forwarded from the CDB when enabled
  always_comb begin
    disp_vj = vj_q[disp_idx];
    disp_vk = vk_q[disp_idx];
`ifdef RS_WAKEUP_DISPATCH_EN
    if (wake_j[disp_idx]) disp_vj = wake_vj[disp_idx];
    if (wake_k[disp_idx]) disp_vk = wake_vk[disp_idx];
`endif
  end

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_W)
  ) u_free_sel (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_W)
  ) u_ready_sel (
    .req   (ready_vec),
    .found (disp_found),
    .idx   (disp_idx)
  );

  // Entry state: wake-up, free on dispatch, write on issue.
  // The free search sees the dispatching entry as still busy, so a slot
  // freed this cycle cannot be reused by the issue in the same cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy  <= '0;
      pendj <= '0;
      pendk <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        rob_q[i] <= '0;
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clr_in) begin
        busy  <= '0;
        pendj <= '0;
        pendk <= '0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (wake_j[i]) begin
            vj_q[i]  <= wake_vj[i];
            pendj[i] <= FALSE;
          end
          if (wake_k[i]) begin
            vk_q[i]  <= wake_vk[i];
            pendk[i] <= FALSE;
          end
        end
        if (disp_found) begin
          busy[disp_idx] <= FALSE;
        end
        if (issue_fire) begin
          busy[free_idx]  <= TRUE;
          op_q[free_idx]  <= issue_op;
          vj_q[free_idx]  <= iss_vj;
          vk_q[free_idx]  <= iss_vk;
          qj_q[free_idx]  <= issue_rs1_tag;
          qk_q[free_idx]  <= issue_rs2_tag;
          pendj[free_idx] <= iss_pendj;
          pendk[free_idx] <= iss_pendk;
          rob_q[free_idx] <= issue_rob_index;
          pc_q[free_idx]  <= issue_pc;
          imm_q[free_idx] <= issue_imm;
        end
      end
    end
  end

  // Registered ALU dispatch strobe and payload
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rs_to_alu_ready     <= FALSE;
      rs_to_alu_op        <= '0;
      rs_to_alu_rs1       <= '0;
      rs_to_alu_rs2       <= '0;
      rs_to_alu_rob_index <= '0;
      rs_to_alu_PC        <= '0;
      rs_to_alu_imm       <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        rs_to_alu_ready <= FALSE;
      end else if (disp_found) begin
        rs_to_alu_ready     <= TRUE;
        rs_to_alu_op        <= op_q[disp_idx];
        rs_to_alu_rs1       <= disp_vj;
        rs_to_alu_rs2       <= disp_vk;
        rs_to_alu_rob_index <= rob_q[disp_idx];
        rs_to_alu_PC        <= pc_q[disp_idx];
        rs_to_alu_imm       <= imm_q[disp_idx];
      end else begin
        rs_to_alu_ready <= FALSE;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a dispatch scoreboard.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1_val, issue_rs2_val;
  logic        issue_rs1_pend, issue_rs2_pend;
  logic [3:0]  issue_rs1_tag, issue_rs2_tag, issue_rob_index;
  logic [31:0] issue_pc, issue_imm;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [31:0] alu_cdb_result, lsb_cdb_result;
  logic [3:0]  alu_cdb_rob_index, lsb_cdb_rob_index;
  logic        rs_to_alu_ready;
  logic [5:0]  rs_to_alu_op;
  logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm;
  logic [3:0]  rs_to_alu_rob_index;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  rob;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  reservation_station dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .issue_valid         (issue_valid),
    .issue_op            (issue_op),
    .issue_rs1_val       (issue_rs1_val),
    .issue_rs2_val       (issue_rs2_val),
    .issue_rs1_pend      (issue_rs1_pend),
    .issue_rs2_pend      (issue_rs2_pend),
    .issue_rs1_tag       (issue_rs1_tag),
    .issue_rs2_tag       (issue_rs2_tag),
    .issue_rob_index     (issue_rob_index),
    .issue_pc            (issue_pc),
    .issue_imm           (issue_imm),
    .rs_full             (rs_full),
    .alu_cdb_valid       (alu_cdb_valid),
    .alu_cdb_result      (alu_cdb_result),
    .alu_cdb_rob_index   (alu_cdb_rob_index),
    .lsb_cdb_valid       (lsb_cdb_valid),
    .lsb_cdb_result      (lsb_cdb_result),
    .lsb_cdb_rob_index   (lsb_cdb_rob_index),
    .rs_to_alu_ready     (rs_to_alu_ready),
    .rs_to_alu_op        (rs_to_alu_op),
    .rs_to_alu_rs1       (rs_to_alu_rs1),
    .rs_to_alu_rs2       (rs_to_alu_rs2),
    .rs_to_alu_rob_index (rs_to_alu_rob_index),
    .rs_to_alu_PC        (rs_to_alu_PC),
    .rs_to_alu_imm       (rs_to_alu_imm)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [3:0] rob, input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rob = rob; e.pc = pc; e.imm = imm;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then pop and compare any dispatched op
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (rs_to_alu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_dispatch", 32'(rs_to_alu_ready), 32'(0));
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("disp_op",  32'(rs_to_alu_op), 32'(e.op));
        chk("disp_rs1", rs_to_alu_rs1, e.rs1);
        chk("disp_rs2", rs_to_alu_rs2, e.rs2);
        chk("disp_rob", 32'(rs_to_alu_rob_index), 32'(e.rob));
        chk("disp_pc",  rs_to_alu_PC, e.pc);
        chk("disp_imm", rs_to_alu_imm, e.imm);
      end
    end
  endtask

  task automatic do_issue(input logic [5:0] op, input logic [31:0] v1, input logic p1,
                          input logic [3:0] t1, input logic [31:0] v2, input logic p2,
                          input logic [3:0] t2, input logic [3:0] rob,
                          input logic [31:0] pc, input logic [31:0] imm);
    issue_valid = 1'b1; issue_op = op;
    issue_rs1_val = v1; issue_rs1_pend = p1; issue_rs1_tag = t1;
    issue_rs2_val = v2; issue_rs2_pend = p2; issue_rs2_tag = t2;
    issue_rob_index = rob; issue_pc = pc; issue_imm = imm;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    issue_valid = 1'b0; issue_op = '0;
    issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_pend = 1'b0; issue_rs2_pend = 1'b0;
    issue_rs1_tag = '0; issue_rs2_tag = '0; issue_rob_index = '0; issue_pc = '0; issue_imm = '0;
    alu_cdb_valid = 1'b0; alu_cdb_result = '0; alu_cdb_rob_index = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_result = '0; lsb_cdb_rob_index = '0;

    // Reset state
    #12;
    chk("rst_ready", 32'(rs_to_alu_ready), 32'(0));
    chk("rst_full",  32'(rs_full), 32'(0));
    chk("rst_op",    32'(rs_to_alu_op), 32'(0));
    chk("rst_rs1",   rs_to_alu_rs1, 32'(0));
    chk("rst_pc",    rs_to_alu_PC, 32'(0));
    #5 rst_in = 1'b1;
    tick();

    // 1. Ready ADDI dispatches two cycles after issue
    push_exp(OPENUM_ADDI, 32'd5, 32'd0, 4'd2, 32'h100, 32'd3);
    do_issue(OPENUM_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2, 32'h100, 32'd3);
    chk("t1_ready_w", 32'(rs_to_alu_ready), 32'(0));
    tick();
    chk("t1_ready_s", 32'(rs_to_alu_ready), 32'(1));
    tick();
    chk("t1_ready_off", 32'(rs_to_alu_ready), 32'(0));

    // 2. rs1 pending on tag 7, woken by ALU CDB
    push_exp(OPENUM_ADD, 32'h10, 32'h22, 4'd4, 32'h104, 32'd0);
    do_issue(OPENUM_ADD, 32'hFFFF, 1'b1, 4'd7, 32'h22, 1'b0, 4'd0, 4'd4, 32'h104, 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_rob_index = 4'd7; alu_cdb_result = 32'h10;
    tick();
    alu_cdb_valid = 1'b0;
`ifdef RS_WAKEUP_DISPATCH_EN
    chk("t2_ready_fwd", 32'(rs_to_alu_ready), 32'(1));
`else
    chk("t2_ready_early", 32'(rs_to_alu_ready), 32'(0));
    tick();
    chk("t2_ready", 32'(rs_to_alu_ready), 32'(1));
`endif
    tick();

    // 3. Issue/LSB CDB collision captured at issue
    push_exp(OPENUM_SUB, 32'hAB, 32'd5, 4'd6, 32'h108, 32'd0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_index = 4'd3; lsb_cdb_result = 32'hAB;
    do_issue(OPENUM_SUB, 32'h0, 1'b1, 4'd3, 32'd5, 1'b0, 4'd0, 4'd6, 32'h108, 32'd0);
    lsb_cdb_valid = 1'b0;
    tick();
    chk("t3_ready", 32'(rs_to_alu_ready), 32'(1));
    tick();

    // 4. Fill all entries pending on tag 9, drop the 17th, then drain in order
    for (int i = 0; i < 16; i++) begin
      push_exp(OPENUM_ADD, 32'h99, 32'(i), 4'(i), 32'h200 + 32'(4 * i), 32'(i));
      do_issue(OPENUM_ADD, 32'h0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i), 32'h200 + 32'(4 * i), 32'(i));
    end
    chk("t4_full", 32'(rs_full), 32'(1));
    do_issue(OPENUM_XOR, 32'hDEAD, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 4'd5, 32'h500, 32'd0);
    chk("t4_full_drop", 32'(rs_full), 32'(1));
    alu_cdb_valid = 1'b1; alu_cdb_rob_index = 4'd9; alu_cdb_result = 32'h99;
    tick();
    alu_cdb_valid = 1'b0;
`ifdef RS_WAKEUP_DISPATCH_EN
    chk("t4_first", 32'(rs_to_alu_ready), 32'(1));
    chk("t4_full_drop1", 32'(rs_full), 32'(0));
`else
    chk("t4_wait", 32'(rs_to_alu_ready), 32'(0));
    chk("t4_still_full", 32'(rs_full), 32'(1));
    tick();
    chk("t4_first", 32'(rs_to_alu_ready), 32'(1));
    chk("t4_full_drop1", 32'(rs_full), 32'(0));
`endif
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_consec", 32'(rs_to_alu_ready), 32'(1));
    end
    tick();
    chk("t4_drained", 32'(rs_to_alu_ready), 32'(0));
    chk("t4_sb_empty", 32'(exp_q.size()), 32'(0));

    // 5. Flush pending entries; old tags dispatch nothing afterwards
    for (int i = 0; i < 16; i++) begin
      do_issue(OPENUM_OR, 32'h0, 1'b1, 4'd4, 32'h0, 1'b1, 4'd4, 4'(i), 32'h600, 32'd0);
    end
    chk("t5_full", 32'(rs_full), 32'(1));
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    chk("t5_clr_full", 32'(rs_full), 32'(0));
    chk("t5_clr_ready", 32'(rs_to_alu_ready), 32'(0));
    alu_cdb_valid = 1'b1; alu_cdb_rob_index = 4'd4; alu_cdb_result = 32'h44;
    tick();
    alu_cdb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_disp", 32'(rs_to_alu_ready), 32'(0));
    end

    // 6. rdy_in low freezes state and ignores the CDB
    do_issue(OPENUM_BEQ, 32'h0, 1'b1, 4'd6, 32'h3, 1'b0, 4'd0, 4'd9, 32'h304, 32'h40);
    push_exp(OPENUM_AND, 32'd1, 32'd2, 4'd8, 32'h300, 32'd0);
    do_issue(OPENUM_AND, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd8, 32'h300, 32'd0);
    rdy_in = 1'b0;
    alu_cdb_valid = 1'b1; alu_cdb_rob_index = 4'd6; alu_cdb_result = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_ready", 32'(rs_to_alu_ready), 32'(0));
    end
    chk("t6_frozen_rob", 32'(rs_to_alu_rob_index), 32'(last_exp.rob));
    chk("t6_frozen_rs1", rs_to_alu_rs1, last_exp.rs1);
    alu_cdb_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("t6_resume", 32'(rs_to_alu_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_bcast_lost", 32'(rs_to_alu_ready), 32'(0));
    end
    push_exp(OPENUM_BEQ, 32'h77, 32'h3, 4'd9, 32'h304, 32'h40);
    alu_cdb_valid = 1'b1; alu_cdb_rob_index = 4'd6; alu_cdb_result = 32'h77;
    tick();
    alu_cdb_valid = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();
    chk("t6_beq_done", 32'(exp_q.size()), 32'(0));

    // Async reset mid-cycle clears outputs without a clock edge
    push_exp(OPENUM_ADDI, 32'h11, 32'd0, 4'd1, 32'h400, 32'd7);
    do_issue(OPENUM_ADDI, 32'h11, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd1, 32'h400, 32'd7);
    tick();
    chk("t7_ready_pre", 32'(rs_to_alu_ready), 32'(1));
    #2 rst_in = 1'b0;
    #1;
    chk("t7_rst_ready", 32'(rs_to_alu_ready), 32'(0));
    chk("t7_rst_op",    32'(rs_to_alu_op), 32'(0));
    chk("t7_rst_rs1",   rs_to_alu_rs1, 32'(0));
    chk("t7_rst_imm",   rs_to_alu_imm, 32'(0));
    chk("t7_rst_pc",    rs_to_alu_PC, 32'(0));
    #1 rst_in = 1'b1;
    tick();
    chk("t7_post_rst", 32'(rs_to_alu_ready), 32'(0));
    chk("final_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
